// File: rtl/alu_param_pipe_if.sv
// alu_param_pipe_if: command/operand/result bundle for alu_param_pipe
//   master drives: ce, inp_valid[1:0] (bit0 opa, bit1 opb), mode, cmd, opa, opb, cin
//   slave drives:  res (2*WIDTH, zero-extended), out_valid pulse, cout, oflow, g, e, l, err, busy
interface alu_param_pipe_if #(parameter int WIDTH = 8, parameter int CMD_W = 4);
   logic               ce;
   logic [1:0]         inp_valid;
   logic               mode;
   logic [CMD_W-1:0]   cmd;
   logic [WIDTH-1:0]   opa;
   logic [WIDTH-1:0]   opb;
   logic               cin;
   logic [2*WIDTH-1:0] res;
   logic               out_valid;
   logic               cout;
   logic               oflow;
   logic               g;
   logic               e;
   logic               l;
   logic               err;
   logic               busy;
   modport master (output ce, inp_valid, mode, cmd, opa, opb, cin,
                   input res, out_valid, cout, oflow, g, e, l, err, busy);
   modport slave  (input ce, inp_valid, mode, cmd, opa, opb, cin,
                   output res, out_valid, cout, oflow, g, e, l, err, busy);
endinterface

// File: rtl/alu_param_pipe.sv
// alu_param_pipe: width-generic ALU with split-operand wait, timeout and multi-cycle multiply
//   clk   rising-edge clock
//   rst_n synchronous active-low reset
//   bus   alu_param_pipe_if.slave: ce/inp_valid/mode/cmd/opa/opb/cin in; res/out_valid/flags/busy out
module alu_param_pipe #(
   parameter int WIDTH   = 8,
   parameter int CMD_W   = 4,
   parameter int TIMEOUT = 16,
   parameter int MUL_LAT = 3
) (
   input logic             clk,
   input logic             rst_n,
   alu_param_pipe_if.slave bus
);
   localparam int RW = 2 * WIDTH;
   localparam int LW = $clog2(WIDTH);
   localparam int CW = $clog2(TIMEOUT + MUL_LAT + 1);
   typedef enum logic [1:0] {IDLE, WAIT, MUL} state_t;
   state_t           state;
   logic [CW-1:0]    cnt;
   logic [1:0]       have;
   logic             r_mode, r_cin;
   logic [CMD_W-1:0] r_cmd;
   logic [WIDTH-1:0] r_a, r_b;
   logic             s_mode, s_cin;
   logic [CMD_W-1:0] s_cmd;
   logic [WIDTH-1:0] sa, sb, lr, pa, pb;
   logic [LW-1:0]    amt;
   logic [RW-1:0]    rl, rr, p, c_res;
   logic             one_a, one_b, legal, need_a, need_b, av, bv, mul_op, ready, fire, tmo, bad;
   logic             c_cout, c_oflow, c_g, c_e, c_l, c_err;
   // In IDLE everything comes straight from the bus; afterwards the latched command
   // is used and only operands not yet latched are taken from the bus.
   assign s_mode = state == IDLE ? bus.mode : r_mode;
   assign s_cmd  = state == IDLE ? bus.cmd : r_cmd;
   assign s_cin  = state == IDLE ? bus.cin : r_cin;
   assign sa     = (state == IDLE || !have[0]) ? bus.opa : r_a;
   assign sb     = (state == IDLE || !have[1]) ? bus.opb : r_b;
   assign one_a  = s_mode ? (s_cmd == 4 || s_cmd == 5) : (s_cmd == 6 || s_cmd == 8 || s_cmd == 9);
   assign one_b  = s_mode ? (s_cmd == 6 || s_cmd == 7) : (s_cmd == 7 || s_cmd == 10 || s_cmd == 11);
   assign legal  = s_mode ? s_cmd <= 10 : s_cmd <= 13;
   assign need_a = legal && !one_b;
   assign need_b = legal && !one_a;
   assign av     = bus.inp_valid[0] || (state == WAIT && have[0]);
   assign bv     = bus.inp_valid[1] || (state == WAIT && have[1]);
   assign ready  = (av || !need_a) && (bv || !need_b);
   assign mul_op = s_mode && (s_cmd == 9 || s_cmd == 10);
   // Multiply issues its result MUL_LAT-1 edges after the capture edge, counted in cnt.
   assign fire   = state == IDLE ? (|bus.inp_valid && ready && !mul_op) :
                   state == WAIT ? (ready && !mul_op) : cnt == CW'(MUL_LAT - 2);
   assign tmo    = state == WAIT && !ready && cnt == CW'(TIMEOUT);
   assign amt    = sb[LW-1:0];
   assign bad    = |(sb >> LW);
   assign bus.busy = state != IDLE;
   always_comb begin
      {c_cout, c_oflow, c_g, c_e, c_l, c_err} = '0;
      lr = '0;
      rl = {sa, sa} << amt;
      rr = {sa, sa} >> amt;
      pa = s_cmd == 9 ? sa + 1'b1 : sa << 1;
      pb = s_cmd == 9 ? sb + 1'b1 : sb;
      p  = pa * pb;
      if (s_mode) begin
         case (s_cmd)
            0:       {c_cout, lr} = {1'b0, sa} + {1'b0, sb};
            1:       {c_oflow, lr} = {1'b0, sa} - {1'b0, sb};
            2:       {c_cout, lr} = {1'b0, sa} + {1'b0, sb} + (WIDTH + 1)'(s_cin);
            3:       {c_oflow, lr} = {1'b0, sa} - {1'b0, sb} - (WIDTH + 1)'(s_cin);
            4:       {c_cout, lr} = {1'b0, sa} + (WIDTH + 1)'(1);
            5:       {c_oflow, lr} = {1'b0, sa} - (WIDTH + 1)'(1);
            6:       {c_cout, lr} = {1'b0, sb} + (WIDTH + 1)'(1);
            7:       {c_oflow, lr} = {1'b0, sb} - (WIDTH + 1)'(1);
            8:       {c_g, c_e, c_l} = sa > sb ? 3'b100 : sa == sb ? 3'b010 : 3'b001;
            9, 10:   lr = '0;
            default: c_err = 1'b1;
         endcase
      end else begin
         case (s_cmd)
            0:       lr = sa & sb;
            1:       lr = ~(sa & sb);
            2:       lr = sa | sb;
            3:       lr = ~(sa | sb);
            4:       lr = sa ^ sb;
            5:       lr = ~(sa ^ sb);
            6:       lr = ~sa;
            7:       lr = ~sb;
            8:       lr = sa >> 1;
            9:       lr = sa << 1;
            10:      lr = sb >> 1;
            11:      lr = sb << 1;
            12:      begin lr = rl[RW-1:WIDTH]; c_err = bad; end
            13:      begin lr = rr[WIDTH-1:0]; c_err = bad; end
            default: c_err = 1'b1;
         endcase
      end
      c_res = c_err ? '0 : mul_op ? p : RW'({c_cout, lr});
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         have          <= '0;
         bus.res       <= '0;
         bus.out_valid <= 1'b0;
         {bus.cout, bus.oflow, bus.g, bus.e, bus.l, bus.err} <= '0;
      end else if (!bus.ce) begin
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= fire || tmo;
         if (fire || tmo) begin
            bus.res <= tmo ? '0 : c_res;
            {bus.cout, bus.oflow, bus.g, bus.e, bus.l, bus.err} <=
               tmo ? 6'b000001 : {c_cout, c_oflow, c_g, c_e, c_l, c_err};
         end
         case (state)
            IDLE: if (|bus.inp_valid) begin
               {r_mode, r_cmd, r_cin, r_a, r_b} <= {bus.mode, bus.cmd, bus.cin, bus.opa, bus.opb};
               have  <= bus.inp_valid;
               cnt   <= '0;
               state <= !ready ? WAIT : mul_op ? MUL : IDLE;
            end
            WAIT: if (ready) begin
               if (!have[0]) r_a <= bus.opa;
               if (!have[1]) r_b <= bus.opb;
               have  <= 2'b11;
               cnt   <= '0;
               state <= mul_op ? MUL : IDLE;
            end else if (tmo) begin
               state <= IDLE;
            end else begin
               cnt <= cnt + 1'b1;
            end
            default: if (fire) state <= IDLE; else cnt <= cnt + 1'b1;
         endcase
      end
   end
endmodule
